// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU sequencer: opcode map, FSM state
// encodings (visible on the LEDs) and the bit positions of the NZVC flags.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  // Opcode map understood by the combinational ALU
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_MUL = 4'd2,
    ALU_DIV = 4'd3,
    ALU_MOD = 4'd4,
    ALU_AND = 4'd5,
    ALU_OR  = 4'd6,
    ALU_XOR = 4'd7,
    ALU_SLL = 4'd8,
    ALU_SRL = 4'd9
  } alu_op_e;

  localparam logic [3:0] OP_MAX = 4'd9;

  // Sequencer states; the encoding is shown directly on the board LEDs
  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4
  } state_e;

  // Positions inside the 4-bit {N,Z,V,C} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // Opcodes above the last defined operation are rejected by the sequencer
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_sync_edge.sv
// ---------------------------------------------------------------------------
// btn_sync_edge
// Two-flop synchroniser for the raw push-button plus a third flop for
// rising-edge detection. Produces a single-cycle press pulse per rising edge
// of the button no matter how long it is held. No debounce.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic press
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  // Metastability chain followed by the delayed copy used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign press = r_sync2 & ~r_sync3;

endmodule

`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
// Sequential front-end and result stage for the combinational N-bit ALU.
// Collects operand A, operand B and the opcode from the switch bus one value
// per button press, holds them steady for the ALU, then captures the result
// and NZVC flags into display registers. N must be at least 4 because the
// opcode is taken from the low four switch bits.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] data_in,
  input  logic         load_btn,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_s,
  input  logic [N-1:0] alu_q,
  input  logic         alu_ne,
  input  logic         alu_z,
  input  logic         alu_v,
  input  logic         alu_c,
  output logic [N-1:0] result_q,
  output logic [3:0]   flags_q,
  output logic         result_valid,
  output logic         op_err,
  output logic [2:0]   state_o
);

  logic         w_press;
  logic [3:0]   w_op;

  state_e       r_state;
  logic [N-1:0] r_alu_a;
  logic [N-1:0] r_alu_b;
  logic [3:0]   r_alu_s;
  logic [N-1:0] r_result;
  logic [3:0]   r_flags;
  logic         r_result_valid;
  logic         r_op_err;

  btn_sync_edge u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (load_btn),
    .press  (w_press)
  );

  assign w_op = data_in[3:0];

  // Load/execute/show sequencer; every output it drives is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_LOAD_A;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_s        <= '0;
      r_result       <= '0;
      r_flags        <= '0;
      r_result_valid <= 1'b0;
      r_op_err       <= 1'b0;
    end else begin
      // op_err is a single-cycle pulse unless re-armed below
      r_op_err <= 1'b0;
      case (r_state)
        ST_LOAD_A: begin
          if (w_press) begin
            r_alu_a <= data_in;
            r_state <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (w_press) begin
            r_alu_b <= data_in;
            r_state <= ST_LOAD_OP;
          end
        end
        ST_LOAD_OP: begin
          if (w_press) begin
            if (op_legal(w_op)) begin
              r_alu_s <= w_op;
              r_state <= ST_EXEC;
            end else begin
              r_op_err <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          // Operands have been stable for a full cycle; presses are ignored
          r_result               <= alu_q;
          r_flags[FLAG_N]        <= alu_ne;
          r_flags[FLAG_Z]        <= alu_z;
          r_flags[FLAG_V]        <= alu_v;
          r_flags[FLAG_C]        <= alu_c;
          r_result_valid         <= 1'b1;
          r_state                <= ST_SHOW;
        end
        ST_SHOW: begin
          // Result registers keep their value for display until the next EXEC
          if (w_press) begin
            r_result_valid <= 1'b0;
            r_state        <= ST_LOAD_A;
          end
        end
        default: begin
          r_state <= ST_LOAD_A;
        end
      endcase
    end
  end

  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_s        = r_alu_s;
  assign result_q     = r_result;
  assign flags_q      = r_flags;
  assign result_valid = r_result_valid;
  assign op_err       = r_op_err;
  assign state_o      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Self-checking bench for alu_seq_ctrl with N=4. A small ALU model closes the
// loop on the DUT's ALU ports; expected results come from hand-computed
// vectors and are queued when the opcode press is driven, then popped when
// result_valid rises.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data_in = '0;
  logic       load_btn = 1'b0;
  logic [3:0] alu_a, alu_b, alu_s, alu_q;
  logic       alu_ne, alu_z, alu_v, alu_c;
  logic [3:0] result_q, flags_q;
  logic       result_valid, op_err;
  logic [2:0] state_o;

  int checks = 0;
  int passes = 0;
  logic [7:0] sb[$];
  logic prev_rv = 1'b0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [3:0] q;
    logic [3:0] f;
  } vec_t;
  vec_t tv[12];

  alu_seq_ctrl #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_btn(load_btn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_q(alu_q),
    .alu_ne(alu_ne), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
    .result_q(result_q), .flags_q(flags_q), .result_valid(result_valid),
    .op_err(op_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Bench ALU: C only for ADD (carry) / SUB (borrow); V flags divide/mod by zero
  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] s);
    logic [4:0] w;
    logic [7:0] m;
    logic [3:0] q;
    logic v, c;
    q = '0; v = 1'b0; c = 1'b0;
    case (s)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; q = w[3:0]; c = w[4]; end
      4'd1: begin q = a - b; c = (a < b); end
      4'd2: begin m = {4'b0, a} * {4'b0, b}; q = m[3:0]; end
      4'd3: begin if (b == 0) begin q = 4'hF; v = 1'b1; end else q = a / b; end
      4'd4: begin if (b == 0) begin q = a; v = 1'b1; end else q = a % b; end
      4'd5: q = a & b;
      4'd6: q = a | b;
      4'd7: q = a ^ b;
      4'd8: q = a << b;
      4'd9: q = a >> b;
      default: q = '0;
    endcase
    return {q, q[3], (q == 4'd0), v, c};
  endfunction

  always_comb begin
    logic [7:0] r;
    r = alu_model(alu_a, alu_b, alu_s);
    alu_q  = r[7:4];
    alu_ne = r[3];
    alu_z  = r[2];
    alu_v  = r[1];
    alu_c  = r[0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor: each rising result_valid consumes one expected result
  always @(negedge clk) begin
    if (result_valid && !prev_rv) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        chk("result_q", result_q, e[7:4]);
        chk("flags_q", flags_q, e[3:0]);
        chk("state_at_valid", state_o, 3'd4);
      end
    end
    prev_rv = result_valid;
  end

  // Gap for the synchroniser to clear, then a press whose action is visible on return
  task automatic press(input logic [3:0] d);
    repeat (2) @(negedge clk);
    data_in  = d;
    load_btn = 1'b1;
    repeat (3) @(negedge clk);
    load_btn = 1'b0;
  endtask

  task automatic wait_sb();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  // Full A/B/OP/EXEC/SHOW round trip for one table vector
  task automatic run_vec(input vec_t v, input logic [3:0] prev_q);
    press(v.a);
    chk("load_a", alu_a, v.a);
    chk("retain_before_exec", result_q, prev_q);
    press(v.b);
    chk("load_b", alu_b, v.b);
    sb.push_back({v.q, v.f});
    press(v.op);
    chk("exec_state", state_o, 3'd3);
    chk("exec_rv_low", result_valid, 1'b0);
    chk("load_s", alu_s, v.op);
    @(negedge clk);
    chk("rv_latency", result_valid, 1'b1);
    wait_sb();
    press(4'h0);
    chk("show_exit_state", state_o, 3'd0);
    chk("show_exit_rv", result_valid, 1'b0);
    chk("show_retain_q", result_q, v.q);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{4'd3,  4'd5,  4'd0, 4'h8, 4'b1000};
    tv[1]  = '{4'd7,  4'd2,  4'd3, 4'h3, 4'b0000};
    tv[2]  = '{4'd15, 4'd1,  4'd0, 4'h0, 4'b0101};
    tv[3]  = '{4'd2,  4'd5,  4'd1, 4'hD, 4'b1001};
    tv[4]  = '{4'd3,  4'd4,  4'd2, 4'hC, 4'b1000};
    tv[5]  = '{4'd9,  4'd0,  4'd3, 4'hF, 4'b1010};
    tv[6]  = '{4'd9,  4'd4,  4'd4, 4'h1, 4'b0000};
    tv[7]  = '{4'd12, 4'd10, 4'd5, 4'h8, 4'b1000};
    tv[8]  = '{4'd12, 4'd3,  4'd6, 4'hF, 4'b1000};
    tv[9]  = '{4'd6,  4'd6,  4'd7, 4'h0, 4'b0100};
    tv[10] = '{4'd3,  4'd2,  4'd8, 4'hC, 4'b1000};
    tv[11] = '{4'd8,  4'd3,  4'd9, 4'h1, 4'b0000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, 3'd0);
    chk("rst_a", alu_a, 4'd0);
    chk("rst_b", alu_b, 4'd0);
    chk("rst_s", alu_s, 4'd0);
    chk("rst_q", result_q, 4'd0);
    chk("rst_f", flags_q, 4'd0);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_err", op_err, 1'b0);
    rst_n = 1'b1;

    // Held button: one transition only, three edges from button to load
    repeat (3) @(negedge clk);
    data_in  = 4'd6;
    load_btn = 1'b1;
    @(negedge clk);
    chk("held_lat_t0", state_o, 3'd0);
    @(negedge clk);
    chk("held_lat_t1", state_o, 3'd0);
    @(negedge clk);
    chk("held_lat_t2", state_o, 3'd1);
    chk("held_load_a", alu_a, 4'd6);
    repeat (47) @(negedge clk);
    chk("held_single", state_o, 3'd1);
    load_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_release", state_o, 3'd1);
    press(4'd6);
    sb.push_back({4'h0, 4'b0100});
    press(4'd7);
    chk("held_exec", state_o, 3'd3);
    wait_sb();
    press(4'h0);
    chk("held_back_a", state_o, 3'd0);

    // Illegal opcodes rejected: alu_s keeps the previous XOR opcode
    press(4'd8);
    press(4'd3);
    press(4'hC);
    chk("ill_err_pulse", op_err, 1'b1);
    chk("ill_state", state_o, 3'd2);
    chk("ill_s_kept", alu_s, 4'd7);
    @(negedge clk);
    chk("ill_err_one_cycle", op_err, 1'b0);
    press(4'hA);
    chk("ill_boundary_err", op_err, 1'b1);
    chk("ill_boundary_state", state_o, 3'd2);
    sb.push_back({4'h1, 4'b0000});
    press(4'h9);
    chk("ill_recover_state", state_o, 3'd3);
    chk("ill_recover_s", alu_s, 4'd9);
    chk("ill_recover_err", op_err, 1'b0);
    wait_sb();
    press(4'h0);

    // Button held across EXEC: a new press pulse cannot follow within one
    // cycle, so the held level must not cause an extra transition out of SHOW
    press(4'd3);
    press(4'd5);
    sb.push_back({4'h8, 4'b1000});
    repeat (2) @(negedge clk);
    data_in  = 4'd0;
    load_btn = 1'b1;
    repeat (3) @(negedge clk);
    chk("execheld_exec", state_o, 3'd3);
    repeat (8) @(negedge clk);
    chk("execheld_show", state_o, 3'd4);
    load_btn = 1'b0;
    repeat (4) @(negedge clk);
    chk("execheld_stay", state_o, 3'd4);
    wait_sb();
    press(4'h0);

    // Asynchronous reset mid-sequence, between clock edges
    press(4'd3);
    press(4'd5);
    chk("mid_pre_b", alu_b, 4'd5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_state", state_o, 3'd0);
    chk("mid_a", alu_a, 4'd0);
    chk("mid_b", alu_b, 4'd0);
    chk("mid_s", alu_s, 4'd0);
    chk("mid_q", result_q, 4'd0);
    chk("mid_rv", result_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of operations, each ending with a SHOW retention check
    for (int i = 0; i < 12; i++) begin
      run_vec(tv[i], (i == 0) ? 4'h0 : tv[i-1].q);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty_end", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
